// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: opcode map, FSM state encoding
// and the fixed flag values used where an op does not produce a carry.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SLTU = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_SRL  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Logic ops, SLTU and SRL never report a carry.
    localparam logic CARRY_NONE = 1'b0;
    // Reset value of every result flag.
    localparam logic FLAG_RESET = 1'b0;

endpackage

// File: rtl/alu_seq_if.sv
// Operand-issue and result-writeback handshake bundle for alu_seq.
interface alu_seq_if #(
    parameter int WIDTH = 4,
    parameter int OPW   = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] inA;
    logic [WIDTH-1:0] inB;
    logic [OPW-1:0]   op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ans;
    logic             carry;
    logic             zero;

    modport master (
        output in_valid, inA, inB, op, out_ready,
        input  in_ready, out_valid, ans, carry, zero
    );

    modport slave (
        input  in_valid, inA, inB, op, out_ready,
        output in_ready, out_valid, ans, carry, zero
    );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles,
// full 2*WIDTH product; done is asserted for one cycle once the count expires.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic               busy_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            busy_q   <= FLAG_RESET;
        end else if (start) begin
            cnt_q    <= CW'(WIDTH);
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            if (cnt_q != '0) begin
                if (mplier_q[0])
                    acc_q <= acc_q + mcand_q;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q - CW'(1);
            end else begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy    = busy_q;
    assign done    = busy_q && (cnt_q == '0);
    assign product = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with carry/zero flags, iterative multiply and valid/ready
// handshakes on both sides; one operation in flight at a time.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int OPW   = 3
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] ans;
        logic             carry;
    } res_t;

    function automatic res_t alu_eval(input logic [OPW-1:0] op,
                                      input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b);
        res_t           r;
        logic [WIDTH:0] wide;
        r.ans   = '0;
        r.carry = CARRY_NONE;
        wide    = '0;
        case (op)
            OP_ADD: begin
                wide    = {1'b0, a} + {1'b0, b};
                r.ans   = wide[WIDTH-1:0];
                r.carry = wide[WIDTH];
            end
            OP_SUB: begin
                // Bit WIDTH of the widened difference is the borrow.
                wide    = {1'b0, a} - {1'b0, b};
                r.ans   = wide[WIDTH-1:0];
                r.carry = wide[WIDTH];
            end
            OP_AND:  r.ans    = a & b;
            OP_OR:   r.ans    = a | b;
            OP_XOR:  r.ans    = a ^ b;
            OP_SLTU: r.ans[0] = (a < b);
            OP_SRL:  r.ans    = a >> b[SHW-1:0];
            default: r.ans    = '0;
        endcase
        return r;
    endfunction

    state_t             state_q, state_d;
    logic               in_ready_c;
    logic               accept;
    logic               is_mul;
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    res_t               alu_res;

    logic [WIDTH-1:0]   ans_p1;
    logic               carry_p1;
    logic               zero_p1;
    logic               vld_p1;

    assign is_mul  = (bus.op == OP_MUL);
    assign accept  = bus.in_valid && in_ready_c;
    assign alu_res = alu_eval(bus.op, bus.inA, bus.inB);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (bus.inA),
        .b       (bus.inB),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = is_mul ? S_MUL : S_DONE;
            S_MUL: begin
                if (mul_done)       state_d = S_DONE;
                else if (!mul_busy) state_d = S_IDLE;
            end
            S_DONE: begin
                if (accept)             state_d = is_mul ? S_MUL : S_DONE;
                else if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready_c = 1'b0;
        case (state_q)
            S_IDLE:  in_ready_c = 1'b1;
            S_DONE:  in_ready_c = bus.out_ready;
            default: in_ready_c = 1'b0;
        endcase
        mul_start = accept && is_mul;
    end

    // Result stage: single-cycle ops load on accept, MUL loads when the multiplier finishes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ans_p1   <= '0;
            carry_p1 <= FLAG_RESET;
            zero_p1  <= FLAG_RESET;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= (state_d == S_DONE);
            if (accept && !is_mul) begin
                ans_p1   <= alu_res.ans;
                carry_p1 <= alu_res.carry;
                zero_p1  <= (alu_res.ans == '0);
            end else if (state_q == S_MUL && mul_done) begin
                ans_p1   <= mul_product[WIDTH-1:0];
                carry_p1 <= |mul_product[2*WIDTH-1:WIDTH];
                zero_p1  <= (mul_product[WIDTH-1:0] == '0);
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = vld_p1;
    assign bus.ans       = ans_p1;
    assign bus.carry     = carry_p1;
    assign bus.zero      = zero_p1;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=4 and WIDTH=8 with hand-computed results.
module tb_alu_seq;
    import alu_pkg::*;

    logic clk;
    logic rst4;
    logic rst8;
    int   tests;
    int   failed;

    alu_seq_if #(.WIDTH(4), .OPW(3)) b4 ();
    alu_seq_if #(.WIDTH(8), .OPW(3)) b8 ();

    alu_seq #(.WIDTH(4), .OPW(3)) u4 (.clk(clk), .reset(rst4), .bus(b4.slave));
    alu_seq #(.WIDTH(8), .OPW(3)) u8 (.clk(clk), .reset(rst8), .bus(b8.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue4(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b);
        b4.op = o; b4.inA = a; b4.inB = b; b4.in_valid = 1'b1;
        @(negedge clk);
        b4.in_valid = 1'b0;
    endtask

    task automatic issue8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        b8.op = o; b8.inA = a; b8.inB = b; b8.in_valid = 1'b1;
        @(negedge clk);
        b8.in_valid = 1'b0;
    endtask

    task automatic res4(input string tag, input logic [3:0] ea, input logic ec, input logic ez);
        check({tag, "_valid"}, 32'(b4.out_valid), 32'd1);
        check({tag, "_ans"},   32'(b4.ans),       32'(ea));
        check({tag, "_carry"}, 32'(b4.carry),     32'(ec));
        check({tag, "_zero"},  32'(b4.zero),      32'(ez));
    endtask

    task automatic res8(input string tag, input logic [7:0] ea, input logic ec, input logic ez);
        check({tag, "_valid"}, 32'(b8.out_valid), 32'd1);
        check({tag, "_ans"},   32'(b8.ans),       32'(ea));
        check({tag, "_carry"}, 32'(b8.carry),     32'(ec));
        check({tag, "_zero"},  32'(b8.zero),      32'(ez));
    endtask

    task automatic mul4(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] ea, input logic ec);
        issue4(OP_MUL, a, b);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_busy_ready"}, 32'(b4.in_ready), 32'd0);
            check({tag, "_busy_valid"}, 32'(b4.out_valid), 32'd0);
            @(negedge clk);
        end
        check({tag, "_early_valid"}, 32'(b4.out_valid), 32'd0);
        @(negedge clk);
        res4(tag, ea, ec, ea == 4'd0);
    endtask

    initial begin
        tests = 0; failed = 0;
        rst4 = 1'b0; rst8 = 1'b0;
        b4.in_valid = 1'b0; b4.inA = '0; b4.inB = '0; b4.op = '0; b4.out_ready = 1'b1;
        b8.in_valid = 1'b0; b8.inA = '0; b8.inB = '0; b8.op = '0; b8.out_ready = 1'b1;
        #1;
        rst4 = 1'b1; rst8 = 1'b1;
        #2;
        check("rst_ans",   32'(b4.ans),       32'd0);
        check("rst_carry", 32'(b4.carry),     32'd0);
        check("rst_zero",  32'(b4.zero),      32'd0);
        check("rst_valid", 32'(b4.out_valid), 32'd0);
        check("rst8_valid", 32'(b8.out_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst4 = 1'b0; rst8 = 1'b0;
        #1;
        check("idle_ready", 32'(b4.in_ready), 32'd1);
        @(negedge clk);

        // Scenario 1: ADD with latency 1, then drains back to idle
        issue4(OP_ADD, 4'd2, 4'd3);
        res4("add", 4'd5, 1'b0, 1'b0);
        @(negedge clk);
        check("add_drained", 32'(b4.out_valid), 32'd0);

        // Scenario 2: SUB borrow, then XOR issued back-to-back gives zero
        issue4(OP_SUB, 4'd2, 4'd3);
        res4("sub", 4'd15, 1'b1, 1'b0);
        issue4(OP_XOR, 4'd5, 4'd5);
        res4("xor", 4'd0, 1'b0, 1'b1);
        issue4(OP_ADD, 4'd15, 4'd1);
        res4("add_wrap", 4'd0, 1'b1, 1'b1);

        // Scenario 3: iterative multiply
        mul4("mul3x5", 4'd3, 4'd5, 4'd15, 1'b0);
        mul4("mul7x3", 4'd7, 4'd3, 4'd5, 1'b1);
        @(negedge clk);

        // Scenario 4: backpressure holds the result and blocks new ops
        b4.out_ready = 1'b0;
        issue4(OP_ADD, 4'd9, 4'd9);
        res4("bp_add", 4'd2, 1'b1, 1'b0);
        b4.op = OP_OR; b4.inA = 4'd1; b4.inB = 4'd2; b4.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready", 32'(b4.in_ready), 32'd0);
            @(negedge clk);
            res4("bp_hold", 4'd2, 1'b1, 1'b0);
        end
        b4.out_ready = 1'b1;
        b4.op = OP_SRL; b4.inA = 4'd12; b4.inB = 4'd2;
        #1;
        check("bp_release_ready", 32'(b4.in_ready), 32'd1);
        @(negedge clk);
        b4.in_valid = 1'b0;
        res4("srl", 4'd3, 1'b0, 1'b0);
        @(negedge clk);
        check("consumed_valid", 32'(b4.out_valid), 32'd0);
        check("consumed_ans_kept", 32'(b4.ans), 32'd3);

        // Scenario 5: reset in the middle of a multiply
        issue4(OP_MUL, 4'd7, 4'd3);
        @(negedge clk);
        @(negedge clk);
        rst4 = 1'b1;
        #1;
        check("midrst_ans",   32'(b4.ans),       32'd0);
        check("midrst_carry", 32'(b4.carry),     32'd0);
        check("midrst_zero",  32'(b4.zero),      32'd0);
        check("midrst_valid", 32'(b4.out_valid), 32'd0);
        @(negedge clk);
        rst4 = 1'b0;
        #1;
        check("postrst_ready", 32'(b4.in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("postrst_no_stale", 32'(b4.out_valid), 32'd0);
        end

        // Scenario 6: SLTU both ways and SRL using only the low shift bits
        issue4(OP_SLTU, 4'd4, 4'd9);
        res4("sltu_lt", 4'd1, 1'b0, 1'b0);
        issue4(OP_SLTU, 4'd9, 4'd4);
        res4("sltu_ge", 4'd0, 1'b0, 1'b1);
        issue4(OP_SRL, 4'd8, 4'd6);
        res4("srl_mask", 4'd2, 1'b0, 1'b0);
        @(negedge clk);

        // WIDTH=8 instance
        issue8(OP_ADD, 8'd2, 8'd3);
        res8("w8_add", 8'd5, 1'b0, 1'b0);
        issue8(OP_ADD, 8'd200, 8'd100);
        res8("w8_add_wrap", 8'd44, 1'b1, 1'b0);
        issue8(OP_MUL, 8'd200, 8'd2);
        for (int i = 0; i < 8; i++) begin
            check("w8_mul_busy_ready", 32'(b8.in_ready), 32'd0);
            check("w8_mul_busy_valid", 32'(b8.out_valid), 32'd0);
            @(negedge clk);
        end
        check("w8_mul_early_valid", 32'(b8.out_valid), 32'd0);
        @(negedge clk);
        res8("w8_mul", 8'd144, 1'b1, 1'b0);
        @(negedge clk);
        check("w8_drained", 32'(b8.out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
